// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e : loader FSM states
//   INSTR_W : instruction word width
package imem_loader_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // pipeline running, loader idle
    LOAD  = 2'd1,  // pipeline held, waiting for commit presses
    WRITE = 2'd2,  // single-cycle write strobe to instruction memory
    HOLD  = 2'd3   // pipeline still held for a fixed time after loading
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Bundle between the loader, the operator inputs and the instruction-memory write port.
//   master : loader side (samples switches/button/data, drives write port and status)
//   slave  : board/memory side (drives switches/button/data, consumes write port and status)
//   load_mode, commit_btn : raw asynchronous operator inputs
//   data_in               : instruction word presented on the switches
//   imem_wr_en/addr/data  : instruction-memory write port
//   cpu_rst               : active-high pipeline reset
//   word_count, full      : progress of the current load session
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic               load_mode;
  logic               commit_btn;
  logic [INSTR_W-1:0] data_in;
  logic               imem_wr_en;
  logic [ADDR_W-1:0]  imem_wr_addr;
  logic [INSTR_W-1:0] imem_wr_data;
  logic               cpu_rst;
  logic [ADDR_W:0]    word_count;
  logic               full;

  modport master (
    input  load_mode, commit_btn, data_in,
    output imem_wr_en, imem_wr_addr, imem_wr_data, cpu_rst, word_count, full
  );

  modport slave (
    output load_mode, commit_btn, data_in,
    input  imem_wr_en, imem_wr_addr, imem_wr_data, cpu_rst, word_count, full
  );

endinterface

// File: rtl/input_debouncer.sv
// Synchronizes one raw asynchronous input and accepts a new level only after it has
// been stable for DEB_CYCLES consecutive clocks.
//   clk, rst : clock, asynchronous active-low reset
//   i_raw    : raw input (switch or button)
//   o_level  : accepted (debounced) level
//   o_rise   : one-cycle pulse coincident with an accepted 0->1 transition
// Raw edge to accepted level takes 2 + DEB_CYCLES clocks.
module input_debouncer #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      // Any sample equal to the accepted level restarts the stability window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/imem_loader.sv
// Writes operator-entered instructions into sequential instruction-memory addresses,
// one word per debounced commit press, and holds the pipeline in reset while loading
// and for RST_HOLD cycles afterwards so fetch restarts at PC 0.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : imem_loader_if master (operator inputs, write port, cpu_rst, status)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int RST_HOLD   = 4
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.master  bus
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(2 ** ADDR_W);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RST_HOLD - 1);

  logic w_load_level;
  logic w_unused_load_rise;
  logic w_commit_level_unused;
  logic w_commit_rise;

  input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (bus.load_mode),
    .o_level (w_load_level),
    .o_rise  (w_unused_load_rise)
  );

  input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_commit (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (bus.commit_btn),
    .o_level (w_commit_level_unused),
    .o_rise  (w_commit_rise)
  );

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [INSTR_W-1:0]  r_data;
  logic [INSTR_W-1:0]  w_data_nxt;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                r_cpu_rst;
  logic                r_wr_en;
  logic                r_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= HOLD;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      RUN: begin
        if (w_load_level) begin
          w_state_nxt = LOAD;
          w_addr_nxt  = '0;
          w_count_nxt = '0;
        end
      end
      LOAD: begin
        // Leaving load mode takes priority over a coincident commit press.
        if (!w_load_level) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end else if (w_commit_rise && !r_full) begin
          w_state_nxt = WRITE;
          w_data_nxt  = bus.data_in;
        end
      end
      WRITE: begin
        w_state_nxt = LOAD;
        w_addr_nxt  = r_addr + 1'b1;  // wraps at capacity; full stops further writes
        if (r_count != FULL_COUNT) w_count_nxt = r_count + 1'b1;
      end
      HOLD: begin
        if (w_load_level) begin
          w_state_nxt = LOAD;
          w_addr_nxt  = '0;
          w_count_nxt = '0;
        end else if (r_hold == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      default: begin
        w_state_nxt = HOLD;
        w_hold_nxt  = HOLD_LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free and line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_hold    <= HOLD_LOAD;
      r_cpu_rst <= 1'b1;
      r_wr_en   <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_count   <= w_count_nxt;
      r_data    <= w_data_nxt;
      r_hold    <= w_hold_nxt;
      r_cpu_rst <= (w_state_nxt != RUN);
      r_wr_en   <= (w_state_nxt == WRITE);
      r_full    <= (w_count_nxt == FULL_COUNT);
    end
  end

  assign bus.imem_wr_en   = r_wr_en;
  assign bus.imem_wr_addr = r_addr;
  assign bus.imem_wr_data = r_data;
  assign bus.cpu_rst      = r_cpu_rst;
  assign bus.word_count   = r_count;
  assign bus.full         = r_full;

endmodule
